// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and parameter defaults for the conv job sequencer
package conv_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int HI_TIMEOUT_DEF = 15;
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_WAIT_HI,
    S_WAIT_LO,
    S_STORE,
    S_NEXT,
    S_FIN
  } state_e;
endpackage

// File: rtl/conv_job_sequencer_if.sv
// conv_job_sequencer_if: run/busy handshake and operand/result bus between sequencer and conv engine
interface conv_job_sequencer_if
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic dut_run;
  logic dut_busy;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic dut_sram_write_enable;
  modport master (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
    input dut_busy, dut_sram_write_data, dut_sram_write_address, dut_sram_write_enable
  );
  modport slave (
    input dut_run, sram_dut_read_data, wmem_dut_read_data,
    output dut_busy, dut_sram_write_data, dut_sram_write_address, dut_sram_write_enable
  );
endinterface

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: walks a batch of jobs through fetch, engine run and result store
module conv_job_sequencer
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int HI_TIMEOUT = HI_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_b,
  input  logic start,
  input  logic [ADDR_W-1:0] num_jobs,
  output logic seq_busy,
  output logic done,
  output logic err_timeout,
  conv_job_sequencer_if.master eng,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic [DATA_W-1:0] w_rd_data,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data,
  output logic res_wr_en
);
  localparam int TW = $clog2(HI_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] op_in_q, op_in_d, op_w_q, op_w_d, res_q, res_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d, done_q;
  logic unused_addr;
  assign unused_addr = ^eng.dut_sram_write_address;
  assign seq_busy = state_q != S_IDLE;
  assign done = done_q;
  assign err_timeout = err_q;
  assign eng.dut_run = state_q == S_RUN;
  assign eng.sram_dut_read_data = op_in_q;
  assign eng.wmem_dut_read_data = op_w_q;
  assign in_rd_addr = idx_q;
  assign w_rd_addr = idx_q;
  assign res_wr_addr = idx_q;
  assign res_wr_data = res_q;
  assign res_wr_en = state_q == S_STORE;
  // next state; the timeout counter includes the run cycle, so busy may stay low HI_TIMEOUT cycles from the run pulse
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    op_in_d = op_in_q;
    op_w_d = op_w_q;
    res_d = res_q;
    tmo_d = tmo_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        cnt_d = num_jobs;
        idx_d = '0;
        err_d = 1'b0;
        state_d = num_jobs == '0 ? S_FIN : S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        op_in_d = in_rd_data;
        op_w_d = w_rd_data;
        state_d = S_RUN;
      end
      S_RUN: begin
        tmo_d = TW'(1);
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: if (eng.dut_busy) state_d = S_WAIT_LO;
      else if (tmo_q == TW'(HI_TIMEOUT - 1)) begin
        err_d = 1'b1;
        state_d = S_FIN;
      end else tmo_d = tmo_q + 1'b1;
      S_WAIT_LO: if (!eng.dut_busy && eng.dut_sram_write_enable) begin
        res_d = eng.dut_sram_write_data;
        state_d = S_STORE;
      end
      S_STORE: state_d = S_NEXT;
      S_NEXT: begin
        idx_d = idx_q + 1'b1;
        state_d = idx_d == cnt_q ? S_FIN : S_FETCH;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; done is registered so it pulses the cycle after FIN
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      op_in_q <= '0;
      op_w_q <= '0;
      res_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      op_in_q <= op_in_d;
      op_w_q <= op_w_d;
      res_q <= res_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      done_q <= state_q == S_FIN;
    end
  end
endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: directed scenarios against a small binary conv engine and backing memories
module tb_conv_job_sequencer;
  localparam int H = 15;
  logic clk = 1'b0;
  logic reset_b = 1'b1;
  logic start = 1'b0;
  logic [11:0] num_jobs = '0;
  logic seq_busy, done, err_timeout, res_wr_en;
  logic [11:0] in_rd_addr, w_rd_addr, res_wr_addr;
  logic [15:0] in_rd_data, w_rd_data, res_wr_data;
  logic [15:0] in_mem [16];
  logic [15:0] w_mem [16];
  logic eng_busy_q, eng_we_q, eng_dead;
  logic [1:0] eng_cnt_q;
  logic [15:0] eng_data_q;
  int comp = 0;
  int mism = 0;
  int cyc = 0;
  int run_cnt, wr_cnt, done_cnt, done_cyc, excl_bad;
  int run_cyc [$];
  logic [11:0] wr_addr [$];
  logic [15:0] wr_data [$];

  conv_job_sequencer_if #(.ADDR_W(12), .DATA_W(16)) eng ();

  conv_job_sequencer #(.ADDR_W(12), .DATA_W(16), .HI_TIMEOUT(H)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .num_jobs(num_jobs),
    .seq_busy(seq_busy), .done(done), .err_timeout(err_timeout), .eng(eng),
    .in_rd_addr(in_rd_addr), .w_rd_addr(w_rd_addr), .in_rd_data(in_rd_data), .w_rd_data(w_rd_data),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data), .res_wr_en(res_wr_en)
  );

  always #5 clk = ~clk;

  // 4x4 binary image against 3x3 binary kernel: output bit set where the window matches exactly
  function automatic logic [15:0] conv(input logic [15:0] img, input logic [15:0] k);
    logic [15:0] r;
    logic hit;
    r = '0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) begin
        hit = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (img[(a + i) * 4 + b + j] != k[i * 3 + j]) hit = 1'b0;
        r[a * 2 + b] = hit;
      end
    return r;
  endfunction

  assign eng.dut_busy = eng_busy_q & ~eng_dead;
  assign eng.dut_sram_write_enable = eng_we_q;
  assign eng.dut_sram_write_data = eng_data_q;
  assign eng.dut_sram_write_address = '0;

  // engine: busy the cycle after run for three cycles, write enable stays high once set
  always @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      eng_busy_q <= 1'b0;
      eng_we_q <= 1'b0;
      eng_cnt_q <= '0;
      eng_data_q <= '0;
    end else if (eng.dut_run && !eng_dead) begin
      eng_busy_q <= 1'b1;
      eng_cnt_q <= 2'd3;
    end else if (eng_busy_q) begin
      eng_cnt_q <= eng_cnt_q - 2'd1;
      if (eng_cnt_q == 2'd1) begin
        eng_busy_q <= 1'b0;
        eng_we_q <= 1'b1;
        eng_data_q <= conv(eng.sram_dut_read_data, eng.wmem_dut_read_data);
      end
    end
  end

  always @(posedge clk) begin
    in_rd_data <= in_mem[in_rd_addr[3:0]];
    w_rd_data <= w_mem[w_rd_addr[3:0]];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (eng.dut_run) begin run_cnt++; run_cyc.push_back(cyc); end
    if (res_wr_en) begin wr_cnt++; wr_addr.push_back(res_wr_addr); wr_data.push_back(res_wr_data); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (int'(eng.dut_run) + int'(res_wr_en) + int'(done) > 1) excl_bad++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    run_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    run_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  task automatic launch(input logic [11:0] n, output int s);
    num_jobs = n;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) tick();
    comp++;
    if (done_cnt == 0) begin mism++; $display("FAIL done_wait: no done within %0d cycles", lim); end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_b = 1'b1;
    repeat (3) tick();
    comp++;
    if ({seq_busy, done, err_timeout, eng.dut_run, res_wr_en, in_rd_addr, w_rd_addr, res_wr_addr,
         res_wr_data, eng.sram_dut_read_data, eng.wmem_dut_read_data} !== '0) begin
      mism++; $display("FAIL reset_outputs: some output nonzero, busy=%b done=%b", seq_busy, done);
    end
    reset_b = 1'b0;
    tick();
    comp++;
    if (seq_busy !== 1'b0) begin mism++; $display("FAIL idle_after_reset: busy=%b want 0", seq_busy); end
  endtask

  task automatic test_single();
    int s;
    clear_log();
    launch(12'd1, s);
    wait_done(100);
    comp++;
    if (run_cnt !== 1) begin mism++; $display("FAIL single_runs: got %0d want 1", run_cnt); end
    comp++;
    if (wr_cnt !== 1) begin mism++; $display("FAIL single_writes: got %0d want 1", wr_cnt); end
    comp++;
    if (wr_addr[0] !== 12'd0 || wr_data[0] !== 16'h000F) begin
      mism++; $display("FAIL single_write: addr %h data %h want 000/000f", wr_addr[0], wr_data[0]);
    end
    comp++;
    if (done_cnt !== 1) begin mism++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    comp++;
    if (err_timeout !== 1'b0) begin mism++; $display("FAIL single_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [15:0] exp_d [3] = '{16'h000F, 16'h000C, 16'h0003};
    clear_log();
    launch(12'd3, s);
    wait_done(200);
    comp++;
    if (wr_cnt !== 3) begin mism++; $display("FAIL b2b_writes: got %0d want 3", wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      comp++;
      if (wr_addr[i] !== 12'(i) || wr_data[i] !== exp_d[i]) begin
        mism++; $display("FAIL b2b_write%0d: addr %h data %h want %h/%h", i, wr_addr[i], wr_data[i], i, exp_d[i]);
      end
    end
    comp++;
    if (run_cyc[1] - run_cyc[0] !== 9 || run_cyc[2] - run_cyc[1] !== 9) begin
      mism++; $display("FAIL b2b_spacing: %0d,%0d want 9,9", run_cyc[1] - run_cyc[0], run_cyc[2] - run_cyc[1]);
    end
    comp++;
    if (done_cnt !== 1) begin mism++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_jobs();
    int s;
    clear_log();
    launch(12'd0, s);
    wait_done(20);
    comp++;
    if (done_cyc - s !== 2) begin mism++; $display("FAIL zero_latency: got %0d want 2", done_cyc - s); end
    comp++;
    if (run_cnt !== 0 || wr_cnt !== 0) begin mism++; $display("FAIL zero_activity: runs %0d writes %0d want 0/0", run_cnt, wr_cnt); end
    comp++;
    if (done_cnt !== 1) begin mism++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    int s;
    eng_dead = 1'b1;
    clear_log();
    launch(12'd2, s);
    wait_done(100);
    comp++;
    if (err_timeout !== 1'b1) begin mism++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
    comp++;
    if (done_cyc - run_cyc[0] !== H + 1) begin
      mism++; $display("FAIL timeout_latency: done %0d cycles after WAIT_HI entry want %0d", done_cyc - run_cyc[0] - 1, H);
    end
    comp++;
    if (wr_cnt !== 0 || run_cnt !== 1) begin mism++; $display("FAIL timeout_activity: writes %0d runs %0d want 0/1", wr_cnt, run_cnt); end
    eng_dead = 1'b0;
  endtask

  task automatic test_start_in_wait_lo();
    int s;
    clear_log();
    launch(12'd3, s);
    tick();
    comp++;
    if (err_timeout !== 1'b0) begin mism++; $display("FAIL err_clear: got %b want 0", err_timeout); end
    for (int i = 0; i < 20 && run_cnt == 0; i++) tick();
    repeat (2) tick();
    num_jobs = 12'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    comp++;
    if (wr_cnt !== 3 || wr_addr[2] !== 12'd2 || wr_data[2] !== 16'h0003) begin
      mism++; $display("FAIL ignore_start_writes: count %0d last %h/%h want 3 002/0003", wr_cnt, wr_addr[2], wr_data[2]);
    end
    comp++;
    if (run_cyc[1] - run_cyc[0] !== 9) begin mism++; $display("FAIL ignore_start_spacing: got %0d want 9", run_cyc[1] - run_cyc[0]); end
    comp++;
    if (done_cnt !== 1) begin mism++; $display("FAIL ignore_start_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_batch();
    int s;
    clear_log();
    launch(12'd3, s);
    for (int i = 0; i < 40 && run_cnt < 2; i++) tick();
    repeat (2) tick();
    reset_b = 1'b1;
    #1;
    comp++;
    if ({seq_busy, done, err_timeout, eng.dut_run, res_wr_en, in_rd_addr, w_rd_addr, res_wr_addr,
         res_wr_data, eng.sram_dut_read_data, eng.wmem_dut_read_data} !== '0) begin
      mism++; $display("FAIL midreset_outputs: busy=%b addr=%h data=%h want all 0", seq_busy, res_wr_addr, res_wr_data);
    end
    tick();
    reset_b = 1'b0;
    repeat (30) tick();
    comp++;
    if (done_cnt !== 0 || wr_cnt !== 1) begin mism++; $display("FAIL midreset_abandon: done %0d writes %0d want 0/1", done_cnt, wr_cnt); end
    clear_log();
    launch(12'd1, s);
    wait_done(100);
    comp++;
    if (wr_cnt !== 1 || wr_addr[0] !== 12'd0 || wr_data[0] !== 16'h000F || done_cnt !== 1) begin
      mism++; $display("FAIL midreset_restart: writes %0d addr %h data %h done %0d want 1 000 000f 1", wr_cnt, wr_addr[0], wr_data[0], done_cnt);
    end
  endtask

  task automatic test_exclusive();
    comp++;
    if (excl_bad !== 0) begin mism++; $display("FAIL exclusive_pulses: %0d overlapping cycles want 0", excl_bad); end
  endtask

  initial begin
    eng_dead = 1'b0;
    excl_bad = 0;
    for (int i = 0; i < 16; i++) begin in_mem[i] = '0; w_mem[i] = '0; end
    in_mem[0] = 16'hFFFF; w_mem[0] = 16'h01FF;
    in_mem[1] = 16'h0F00; w_mem[1] = 16'h0038;
    in_mem[2] = 16'h000F; w_mem[2] = 16'h0007;
    clear_log();
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_jobs();
    test_timeout();
    test_start_in_wait_lo();
    test_reset_mid_batch();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, mism);
    $finish;
  end
endmodule

// File: doc/conv_job_sequencer.md
CONV_JOB_SEQUENCER -- requirements
Module: conv_job_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning width of all memory and result addresses.
REQ-002 SHALL have parameter DATA_W, default 16, meaning width of all memory data words.
REQ-003 SHALL have parameter HI_TIMEOUT, default 15, meaning the maximum number of cycles allowed for dut_busy to rise after a run pulse.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port reset_b, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: launches a batch; sampled only in IDLE.
REQ-007 SHALL have port num_jobs, input, ADDR_W bits: job count, latched on start.
REQ-008 SHALL have port seq_busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at batch end.
REQ-010 SHALL have port err_timeout, output, 1 bit: sticky flag, cleared by the next accepted start.
REQ-011 SHALL have port dut_run, output, 1 bit: run pulse to the conv engine.
REQ-012 SHALL have port dut_busy, input, 1 bit: busy from the conv engine.
REQ-013 SHALL have ports sram_dut_read_data and wmem_dut_read_data, output, DATA_W bits each: operands presented to the engine.
REQ-014 SHALL have ports dut_sram_write_data (input, DATA_W), dut_sram_write_address (input, ADDR_W, ignored) and dut_sram_write_enable (input, 1 bit): the engine result.
REQ-015 SHALL have ports in_rd_addr and w_rd_addr (output, ADDR_W each) and in_rd_data and w_rd_data (input, DATA_W each) for the backing memories, which have 1-cycle synchronous read.
REQ-016 SHALL have ports res_wr_addr (output, ADDR_W), res_wr_data (output, DATA_W) and res_wr_en (output, 1 bit) for the result memory write port.

Function
REQ-017 SHALL implement the states IDLE, FETCH, LOAD, RUN, WAIT_HI, WAIT_LO, STORE, NEXT and FIN.
REQ-018 SHALL, in IDLE with start=1, latch num_jobs, clear the job index and err_timeout, and go to FIN if num_jobs=0, else to FETCH.
REQ-019 SHALL, in FETCH, drive in_rd_addr=w_rd_addr=job index and go to LOAD.
REQ-020 SHALL, in LOAD, register in_rd_data and w_rd_data into operand registers and go to RUN.
REQ-021 SHALL hold the operand registers on sram_dut_read_data and wmem_dut_read_data from LOAD until the next LOAD.
REQ-022 SHALL, in RUN, assert dut_run for exactly one cycle and go to WAIT_HI.
REQ-023 SHALL, in WAIT_HI, go to WAIT_LO when dut_busy=1.
REQ-024 SHALL, in WAIT_HI, set err_timeout and go to FIN if dut_busy stays low for HI_TIMEOUT cycles.
REQ-025 SHALL, in WAIT_LO, capture dut_sram_write_data into the result register and go to STORE when dut_busy=0 and dut_sram_write_enable=1.
REQ-026 SHALL NOT use a rising edge of dut_sram_write_enable as the completion qualifier, because the engine may hold that signal high across jobs.
REQ-027 SHALL, in STORE, assert res_wr_en for one cycle with res_wr_addr=job index and res_wr_data=result register.
REQ-028 SHALL, in NEXT, increment the job index and go to FIN if the new index equals the latched count, else to FETCH.
REQ-029 SHALL, in FIN, pulse done for one cycle and return to IDLE.
REQ-030 SHALL ignore start in every state except IDLE, and changes to num_jobs after latching.
REQ-031 SHALL treat num_jobs=2^ADDR_W-1 as the maximum batch size and never wrap the job index within a batch.
REQ-032 SHALL keep dut_run, res_wr_en and done mutually exclusive in any cycle.

Reset
REQ-033 SHALL, on reset_b=1, immediately enter IDLE and clear the job index, latched count, operand registers, result register, all address outputs, dut_run, res_wr_en, done, seq_busy and err_timeout.
REQ-034 SHALL, when reset is asserted mid-batch, abandon the batch with no done pulse and no further memory write.

Structure
REQ-035 SHALL take the state encoding, ADDR_W/DATA_W defaults and HI_TIMEOUT default from a shared package conv_pkg.
REQ-036 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-037 SHALL be verified with num_jobs=1, in[0]=0xFFFF and w[0]=0x01FF against the conv engine: one run pulse, then res_wr_en with addr 0 and data 0x000F, then done.
REQ-038 SHALL be verified with num_jobs=3 against the engine: writes to addresses 0,1,2 in order, a FETCH-to-FETCH spacing of exactly 9 cycles, and done once.
REQ-039 SHALL be verified with num_jobs=0: done 2 cycles after start, with no dut_run and no res_wr_en.
REQ-040 SHALL be verified with dut_busy tied to 0: err_timeout=1 and done exactly HI_TIMEOUT cycles after entry to WAIT_HI, and no write.
REQ-041 SHALL be verified by asserting reset_b during the second job's WAIT_LO: all outputs 0 that cycle, no done, and a clean restart on the next start.
REQ-042 SHALL be verified by pulsing start during WAIT_LO: no effect on the job index, outputs or done count.
